// File: rtl/dnpcie_aurora_pkg.sv
// dnpcie_aurora_pkg: shared state encoding and default timing constants for the Aurora link sequencer.
package dnpcie_aurora_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      GT_RST    = 3'd1,
      CORE_RST  = 3'd2,
      WAIT_LINK = 3'd3,
      UP        = 3'd4,
      FAIL      = 3'd5
   } aurora_link_state_t;

   localparam int DEF_GT_RESET_CYCLES   = 128;
   localparam int DEF_CORE_RESET_CYCLES = 64;
   localparam int DEF_LINK_TIMEOUT      = 1048576;
   localparam int DEF_MAX_RETRIES       = 7;
   localparam int DEF_HARD_ERR_RECOVER  = 1;
   localparam int SOFT_ERR_W            = 16;

endpackage

// File: rtl/dnpcie_aurora_link_ctrl_sync.sv
// dnpcie_sync_2ff: per-bit two-flop synchroniser for status inputs arriving from the core clock domain.
module dnpcie_sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   (* ASYNC_REG = "TRUE" *) logic [W-1:0] meta_q;
   (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/dnpcie_aurora_link_ctrl.sv
// dnpcie_aurora_link_ctrl: bring-up, retry and recovery sequencer for the single-lane Aurora core.
// Outputs are registered and decoded from the next state so they move on the same edge as the state.
module dnpcie_aurora_link_ctrl
   import dnpcie_aurora_pkg::*;
#(
   parameter int GT_RESET_CYCLES   = DEF_GT_RESET_CYCLES,
   parameter int CORE_RESET_CYCLES = DEF_CORE_RESET_CYCLES,
   parameter int LINK_TIMEOUT      = DEF_LINK_TIMEOUT,
   parameter int MAX_RETRIES       = DEF_MAX_RETRIES,
   parameter int HARD_ERR_RECOVER  = DEF_HARD_ERR_RECOVER
) (
   input  logic                  init_clk_in,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clr_counters,
   input  logic                  lane_up,
   input  logic                  channel_up,
   input  logic                  hard_err,
   input  logic                  soft_err,
   input  logic                  pll_not_locked,
   output logic                  power_down_out,
   output logic                  gt_reset_out,
   output logic                  core_reset_out,
   output logic                  link_ok,
   output logic                  link_fail,
   output logic [2:0]            state,
   output logic [3:0]            retry_count,
   output logic [SOFT_ERR_W-1:0] soft_err_count
);

   localparam int PH_MAX = (GT_RESET_CYCLES > CORE_RESET_CYCLES) ? GT_RESET_CYCLES : CORE_RESET_CYCLES;
   localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam int TW     = (LINK_TIMEOUT > 1) ? $clog2(LINK_TIMEOUT) : 1;

   localparam logic [PW-1:0] PH_GT_LAST   = PW'(GT_RESET_CYCLES - 1);
   localparam logic [PW-1:0] PH_CORE_LAST = PW'(CORE_RESET_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST      = TW'(LINK_TIMEOUT - 1);
   localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

   logic [4:0] sync_out;
   logic       lane_s, chan_s, herr_s, serr_s, pll_s;
   logic       unused_lane;

   dnpcie_sync_2ff #(.W(5)) u_sync (
      .clk (init_clk_in),
      .rst (reset),
      .d   ({pll_not_locked, soft_err, hard_err, channel_up, lane_up}),
      .q   (sync_out)
   );

   assign {pll_s, serr_s, herr_s, chan_s, lane_s} = sync_out;
   assign unused_lane = lane_s;

   aurora_link_state_t    state_q, state_d;
   logic [PW-1:0]         ph_q, ph_d;
   logic [TW-1:0]         to_q, to_d;
   logic [3:0]            retry_q, retry_d;
   logic [SOFT_ERR_W-1:0] soft_err_count_q, soft_err_count_d;
   logic                  serr_prev_q;
   logic                  power_down_q, power_down_d;
   logic                  gt_reset_q, gt_reset_d;
   logic                  core_reset_q, core_reset_d;
   logic                  link_ok_q, link_ok_d;
   logic                  link_fail_q, link_fail_d;
   logic                  retry_req, state_chg, serr_rise;

   always_comb begin
      state_d   = state_q;
      retry_req = 1'b0;
      case (state_q)
         IDLE:      if (enable) state_d = GT_RST;
         GT_RST:    if (!pll_s && ph_q == PH_GT_LAST) state_d = CORE_RST;
         CORE_RST:  if (ph_q == PH_CORE_LAST) state_d = WAIT_LINK;
         WAIT_LINK: begin
            if (pll_s) state_d = GT_RST;
            else if (chan_s) state_d = UP;
            else retry_req = (to_q == TO_LAST);
         end
         UP: begin
            if (pll_s) state_d = GT_RST;
            else retry_req = !chan_s || (herr_s && HARD_ERR_RECOVER != 0);
         end
         FAIL:      state_d = FAIL;
         default:   state_d = IDLE;
      endcase
      if (retry_req) state_d = (retry_q == RETRY_MAX) ? FAIL : GT_RST;
      // Dropping enable beats every other transition, including a pending retry.
      if (!enable) begin
         retry_req = 1'b0;
         state_d   = IDLE;
      end
   end

   always_comb begin
      state_chg        = state_d != state_q;
      serr_rise        = serr_s && !serr_prev_q;
      // An unlocked PLL restarts the GT reset hold from zero.
      ph_d             = (state_chg || (state_q == GT_RST && pll_s)) ? '0 : ph_q + PW'(1);
      to_d             = state_chg ? '0 : to_q + TW'(1);
      retry_d          = clr_counters ? 4'd0 :
                         (state_d == UP && state_q != UP) ? 4'd0 :
                         (retry_req && retry_q != RETRY_MAX) ? retry_q + 4'd1 : retry_q;
      soft_err_count_d = clr_counters ? '0 :
                         (state_q == UP && serr_rise && soft_err_count_q != '1) ?
                         soft_err_count_q + SOFT_ERR_W'(1) : soft_err_count_q;
      power_down_d     = state_d inside {IDLE, FAIL};
      gt_reset_d       = state_d inside {IDLE, GT_RST, FAIL};
      core_reset_d     = !(state_d inside {WAIT_LINK, UP});
      link_ok_d        = state_d == UP;
      link_fail_d      = state_d == FAIL;
   end

   always_ff @(posedge init_clk_in or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         ph_q             <= '0;
         to_q             <= '0;
         retry_q          <= '0;
         soft_err_count_q <= '0;
         serr_prev_q      <= 1'b0;
         power_down_q     <= 1'b1;
         gt_reset_q       <= 1'b1;
         core_reset_q     <= 1'b1;
         link_ok_q        <= 1'b0;
         link_fail_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         ph_q             <= ph_d;
         to_q             <= to_d;
         retry_q          <= retry_d;
         soft_err_count_q <= soft_err_count_d;
         serr_prev_q      <= serr_s;
         power_down_q     <= power_down_d;
         gt_reset_q       <= gt_reset_d;
         core_reset_q     <= core_reset_d;
         link_ok_q        <= link_ok_d;
         link_fail_q      <= link_fail_d;
      end
   end

   assign power_down_out = power_down_q;
   assign gt_reset_out   = gt_reset_q;
   assign core_reset_out = core_reset_q;
   assign link_ok        = link_ok_q;
   assign link_fail      = link_fail_q;
   assign state          = state_q;
   assign retry_count    = retry_q;
   assign soft_err_count = soft_err_count_q;

endmodule

// File: doc/dnpcie_aurora_link_ctrl.md
# dnpcie_aurora_link_ctrl

Link bring-up and recovery sequencer for the single-lane DNPCIe Aurora core. It drives the core's `power_down`, `gt_reset` and `reset` inputs in the order the core requires, and watches `lane_up`, `channel_up` and the error flags. It retries a failed or dropped link a bounded number of times, counts soft errors, and presents one registered status word to the register bank. It runs on the free-running init clock, alongside the core wrapper.

## Interface
- `GT_RESET_CYCLES`, default 128: cycles `gt_reset_out` is held (with `core_reset_out`) per attempt.
- `CORE_RESET_CYCLES`, default 64: cycles `core_reset_out` is held after `gt_reset_out` releases.
- `LINK_TIMEOUT`, default 1048576: cycles allowed from reset release to `channel_up`.
- `MAX_RETRIES`, default 7: retries before declaring failure; range 1..15.
- `HARD_ERR_RECOVER`, default 1: 1 means a `hard_err` seen in UP forces a re-sequence.
- `init_clk_in` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: level; 1 brings the link up, 0 powers it down.
- `clr_counters` in 1: single-cycle pulse; clears `soft_err_count` and `retry_count`.
- `lane_up`, `channel_up`, `hard_err`, `soft_err`, `pll_not_locked` in 1 each: from the core wrapper, asynchronous to `init_clk_in`.
- `power_down_out` in the core's `power_down`, `gt_reset_out` to `gt_reset`, `core_reset_out` to `reset`: out 1 each.
- `link_ok` out 1: state is UP.
- `link_fail` out 1: state is FAIL.
- `state` out 3: encoded state, for debug and registers.
- `retry_count` out 4: retries consumed since the last UP or clear.
- `soft_err_count` out 16: saturating soft-error count.

## Operation
- Synchronisation: every status input passes through a two-flop synchroniser. All decisions use the synchronised copies.
- Reset values: state = IDLE, `power_down_out` = 1, `gt_reset_out` = 1, `core_reset_out` = 1. All other outputs are 0.
- Output rule: outputs are registered and decoded from the next state, so they change on the same edge as the state.
- States (encoding in brackets):
  - IDLE (0): `power_down_out`, `gt_reset_out` and `core_reset_out` all 1. Moves to GT_RST when `enable` = 1.
  - GT_RST (1): `power_down_out` = 0; `gt_reset_out` and `core_reset_out` = 1.
    - Holds for `GT_RESET_CYCLES` cycles, then moves to CORE_RST.
    - The phase counter reloads to 0 every cycle that synchronised `pll_not_locked` = 1, so the hold restarts.
  - CORE_RST (2): `gt_reset_out` = 0, `core_reset_out` = 1. Holds for `CORE_RESET_CYCLES` cycles, then moves to WAIT_LINK.
  - WAIT_LINK (3): both resets 0; a timeout counter runs.
    - Synchronised `channel_up` = 1: move to UP.
    - Counter reaches `LINK_TIMEOUT - 1`: take the retry path.
  - UP (4): `link_ok` = 1 and `retry_count` clears to 0 on entry.
    - Synchronised `channel_up` falls: take the retry path.
    - Synchronised `hard_err` = 1 and `HARD_ERR_RECOVER` = 1: take the retry path.
  - FAIL (5): `link_fail` = 1, `power_down_out` = 1, both resets 1. Left only by `enable` = 0, which moves to IDLE.
- Retry path:
  - If `retry_count` = `MAX_RETRIES`: move to FAIL.
  - Otherwise increment `retry_count` and move to GT_RST.
- `enable` = 0 in any state: the next state is IDLE. This overrides every other transition.
- `pll_not_locked` = 1 in WAIT_LINK or UP: move to GT_RST without consuming a retry.
- `soft_err_count`:
  - Increments on each rising edge of synchronised `soft_err`, only in UP.
  - Saturates at 0xFFFF.
  - `clr_counters` wins over a simultaneous increment.
- `clr_counters` also zeroes `retry_count`. It does not change state.
- Counter widths: phase counter `$clog2(max(GT_RESET_CYCLES, CORE_RESET_CYCLES))` bits; timeout counter `$clog2(LINK_TIMEOUT)` bits. Both clear on every state change.

## Timing
- Input-to-decision latency is 2 cycles for the synchroniser, plus 1 cycle to the registered output.
- Example: `channel_up` rising at edge N gives `link_ok` = 1 at edge N+3.
- GT_RST lasts exactly `GT_RESET_CYCLES` cycles and CORE_RST exactly `CORE_RESET_CYCLES` cycles, absent PLL unlock.
- `gt_reset_out` never falls while `core_reset_out` = 0, and `core_reset_out` never falls before `gt_reset_out`. These are the core's ordering rules.
- An asynchronous `reset` mid-sequence forces the reset values immediately. Release is synchronous on the next edge.

## Structure
- Shared package `dnpcie_aurora_pkg` holds the state enum `aurora_link_state_t` with the encodings above, plus the default parameter constants.
- Sub-module `dnpcie_sync_2ff`, a per-bit two-flop synchroniser with an ASYNC_REG attribute, is instantiated as a 5-bit vector.

## Test plan
- Nominal bring-up: `enable` = 1, `channel_up` asserted 100 cycles after `core_reset_out` falls. Expect `gt_reset_out` high for 128 cycles, `core_reset_out` high for 64 more, and `link_ok` = 1 exactly 3 cycles after `channel_up`.
- Timeout and fail: `LINK_TIMEOUT` = 1000, `MAX_RETRIES` = 2, `channel_up` never asserted. Expect 3 full sequences, `retry_count` reaching 2, then `link_fail` = 1 with `power_down_out` = 1. Then `enable` = 0 gives IDLE.
- Recovery from UP: after UP, pulse `hard_err` for 1 cycle. Expect re-sequence to GT_RST with `retry_count` = 1, which clears when UP is reached again. Repeat with `HARD_ERR_RECOVER` = 0: expect no state change.
- PLL unlock: assert `pll_not_locked` mid-GT_RST for 50 cycles. Expect the GT_RST hold to restart and total 128 cycles after release. Assert it in UP: expect GT_RST entry with `retry_count` unchanged.
- Soft-error counter: 5 `soft_err` pulses in UP give a count of 5. Pulses in WAIT_LINK are ignored. Preload near 0xFFFF and check saturation. `clr_counters` coincident with a pulse gives 0.
- Asynchronous reset mid-CORE_RST, and `enable` dropped in WAIT_LINK: expect reset values immediately, and IDLE one edge after `enable` falls, respectively.
